// File: rtl/fp_addsub_pipe.sv
// Three-stage floating-point adder/subtractor (align/select, add/LZC, normalise/round/pack).
// Subnormal inputs read as zero, rounding is nearest-even, tiny results flush to signed zero.
module fp_addsub_pipe #(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23,
   parameter int TAG_W = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic                   in_op,
   input  logic [EXP_W+MAN_W:0]   in_x1,
   input  logic [EXP_W+MAN_W:0]   in_x2,
   input  logic [TAG_W-1:0]       in_tag,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [EXP_W+MAN_W:0]   out_y,
   output logic [TAG_W-1:0]       out_tag,
   output logic [3:0]             out_flags
);

   localparam int W       = 1 + EXP_W + MAN_W;
   localparam int X       = MAN_W + 4;   // hidden bit, mantissa, guard, round, sticky
   localparam int LZ_W    = $clog2(X + 2);
   localparam int EXP_MAX = (1 << EXP_W) - 1;
   localparam logic [EXP_W-1:0] EXP_ONES = '1;

   function automatic logic [LZ_W-1:0] lzc(input logic [X:0] v);
      lzc = LZ_W'(X + 1);
      for (int i = 0; i <= X; i++) begin
         if (v[i]) lzc = LZ_W'(X - i);
      end
   endfunction

   // Handshake: a transfer happens on a rising edge where valid && ready; the producer
   // holds its payload stable while valid is high and ready is low. The whole pipe
   // advances together whenever the output register is empty or being drained.
   logic en;
   logic v1_q, v2_q, v3_q;

   assign en       = !v3_q || out_ready;
   assign in_ready = en;

   // ---------------- stage 1: unpack, select larger magnitude, align ----------------
   logic             sa, sb, nan_a, nan_b, inf_a, inf_b, swap, s_big;
   logic [EXP_W-1:0] ex1, ex2, e_big, e_sml, diff;
   logic [MAN_W-1:0] mx1, mx2;
   logic [MAN_W:0]   sg1, sg2, sig_big, sig_sml;
   logic [2*X-1:0]   wide;
   logic [X-1:0]     al_d;
   logic             nan_d, nv_d, inf_d, infs_d;

   always_comb begin
      sa      = in_x1[W-1];
      sb      = in_x2[W-1] ^ in_op;
      ex1     = in_x1[W-2:MAN_W];
      ex2     = in_x2[W-2:MAN_W];
      mx1     = in_x1[MAN_W-1:0];
      mx2     = in_x2[MAN_W-1:0];
      sg1     = (ex1 != '0) ? {1'b1, mx1} : '0;
      sg2     = (ex2 != '0) ? {1'b1, mx2} : '0;
      nan_a   = (ex1 == EXP_ONES) && (mx1 != '0);
      nan_b   = (ex2 == EXP_ONES) && (mx2 != '0);
      inf_a   = (ex1 == EXP_ONES) && (mx1 == '0);
      inf_b   = (ex2 == EXP_ONES) && (mx2 == '0);
      swap    = (ex2 > ex1) || ((ex2 == ex1) && (sg2 > sg1));
      e_big   = swap ? ex2 : ex1;
      e_sml   = swap ? ex1 : ex2;
      sig_big = swap ? sg2 : sg1;
      sig_sml = swap ? sg1 : sg2;
      s_big   = swap ? sb : sa;
      diff    = e_big - e_sml;
      wide    = {sig_sml, 3'b000, {X{1'b0}}} >> diff;
      // Far-away operands only survive as a sticky contribution.
      if (32'(diff) >= X - 1) al_d = {{(X-1){1'b0}}, |sig_sml};
      else                    al_d = wide[2*X-1:X] | {{(X-1){1'b0}}, |wide[X-1:0]};
      nv_d    = inf_a && inf_b && (sa != sb);
      nan_d   = nan_a || nan_b || nv_d;
      inf_d   = inf_a || inf_b;
      infs_d  = inf_a ? sa : sb;
   end

   logic [TAG_W-1:0] tag1_q;
   logic             sub1_q, sgn1_q, nan1_q, nv1_q, inf1_q, infs1_q;
   logic [EXP_W-1:0] exp1_q;
   logic [MAN_W:0]   sig1_q;
   logic [X-1:0]     al1_q;

   // ---------------- stage 2: magnitude add/subtract and leading-zero count ----------------
   logic [X:0]       sum2_d;
   logic [LZ_W-1:0]  lz2_d;

   always_comb begin
      if (sub1_q) sum2_d = {1'b0, sig1_q, 3'b000} - {1'b0, al1_q};
      else        sum2_d = {1'b0, sig1_q, 3'b000} + {1'b0, al1_q};
      lz2_d = lzc(sum2_d);
   end

   logic [TAG_W-1:0] tag2_q;
   logic             sub2_q, sgn2_q, nan2_q, nv2_q, inf2_q, infs2_q;
   logic [EXP_W-1:0] exp2_q;
   logic [X:0]       sum2_q;
   logic [LZ_W-1:0]  lz2_q;

   // ---------------- stage 3: normalise, round to nearest even, pack ----------------
   logic [X:0]       norm;
   logic             g, r, st, lsb, nx, rnd_up;
   logic [MAN_W:0]   man_rnd;
   int               e_res, e_fin;
   logic [W-1:0]     y3_d;
   logic [3:0]       fl3_d;

   always_comb begin
      norm    = sum2_q << lz2_q;
      lsb     = norm[4];
      g       = norm[3];
      r       = norm[2];
      st      = |norm[1:0];
      nx      = g | r | st;
      rnd_up  = g & (r | st | lsb);
      man_rnd = {1'b0, norm[X-1:4]} + {{MAN_W{1'b0}}, rnd_up};
      e_res   = int'(exp2_q) + 1 - int'(lz2_q);
      e_fin   = e_res + int'(man_rnd[MAN_W]);
      y3_d    = '0;
      fl3_d   = '0;
      if (nan2_q) begin
         y3_d  = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};
         fl3_d = {nv2_q, 3'b000};
      end else if (inf2_q) begin
         y3_d  = {infs2_q, EXP_ONES, {MAN_W{1'b0}}};
      end else if (!norm[X]) begin
         // Exact zero: cancellation yields +0, like-signed zeros keep their sign.
         y3_d  = {sgn2_q & !sub2_q, {(W-1){1'b0}}};
      end else if (e_res <= 0) begin
         y3_d  = {sgn2_q, {(W-1){1'b0}}};
         fl3_d = 4'b0011;
      end else if (e_fin >= EXP_MAX) begin
         y3_d  = {sgn2_q, EXP_ONES, {MAN_W{1'b0}}};
         fl3_d = 4'b0101;
      end else begin
         y3_d  = {sgn2_q, EXP_W'(e_fin), man_rnd[MAN_W-1:0]};
         fl3_d = {3'b000, nx};
      end
   end

   logic [TAG_W-1:0] tag3_q;
   logic [W-1:0]     y3_q;
   logic [3:0]       fl3_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v1_q <= 1'b0;  tag1_q <= '0;  sub1_q <= 1'b0; sgn1_q <= 1'b0; exp1_q <= '0;
         sig1_q <= '0;  al1_q <= '0;   nan1_q <= 1'b0; nv1_q <= 1'b0;  inf1_q <= 1'b0;
         infs1_q <= 1'b0;
         v2_q <= 1'b0;  tag2_q <= '0;  sub2_q <= 1'b0; sgn2_q <= 1'b0; exp2_q <= '0;
         sum2_q <= '0;  lz2_q <= '0;   nan2_q <= 1'b0; nv2_q <= 1'b0;  inf2_q <= 1'b0;
         infs2_q <= 1'b0;
         v3_q <= 1'b0;  tag3_q <= '0;  y3_q <= '0;     fl3_q <= '0;
      end else if (en) begin
         v1_q    <= in_valid;
         tag1_q  <= in_tag;
         sub1_q  <= sa ^ sb;
         sgn1_q  <= s_big;
         exp1_q  <= e_big;
         sig1_q  <= sig_big;
         al1_q   <= al_d;
         nan1_q  <= nan_d;
         nv1_q   <= nv_d;
         inf1_q  <= inf_d;
         infs1_q <= infs_d;

         v2_q    <= v1_q;
         tag2_q  <= tag1_q;
         sub2_q  <= sub1_q;
         sgn2_q  <= sgn1_q;
         exp2_q  <= exp1_q;
         sum2_q  <= sum2_d;
         lz2_q   <= lz2_d;
         nan2_q  <= nan1_q;
         nv2_q   <= nv1_q;
         inf2_q  <= inf1_q;
         infs2_q <= infs1_q;

         v3_q    <= v2_q;
         tag3_q  <= tag2_q;
         y3_q    <= y3_d;
         fl3_q   <= fl3_d;
      end
   end

   assign out_valid = v3_q;
   assign out_y     = y3_q;
   assign out_tag   = tag3_q;
   assign out_flags = fl3_q;

endmodule

// File: tb/tb_fp_addsub_pipe.sv
// Directed bench for fp_addsub_pipe: single precision vectors, backpressure, async reset,
// plus one half-precision instance.
module tb_fp_addsub_pipe;

   localparam int TAG_W = 4;
   localparam int W     = 32;
   localparam int HW    = 16;

   logic             clk = 1'b0;
   logic             rst;
   logic             in_valid, in_ready, in_op, out_valid, out_ready;
   logic [W-1:0]     in_x1, in_x2, out_y;
   logic [TAG_W-1:0] in_tag, out_tag;
   logic [3:0]       out_flags;

   logic             h_in_valid, h_in_ready, h_in_op, h_out_valid, h_out_ready;
   logic [HW-1:0]    h_in_x1, h_in_x2, h_out_y;
   logic [TAG_W-1:0] h_in_tag, h_out_tag;
   logic [3:0]       h_out_flags;

   int total = 0;
   int bad   = 0;
   logic [W+TAG_W-1:0] exp_q[$];

   logic [W-1:0] bp_x2 [6] = '{32'h3F800000, 32'h40000000, 32'h40400000,
                               32'h40800000, 32'h40A00000, 32'h40C00000};
   logic [W-1:0] bp_y  [6] = '{32'h40000000, 32'h40400000, 32'h40800000,
                               32'h40A00000, 32'h40C00000, 32'h40E00000};

   always #5 clk = ~clk;

   fp_addsub_pipe #(.EXP_W(8), .MAN_W(23), .TAG_W(TAG_W)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
      .in_x1(in_x1), .in_x2(in_x2), .in_tag(in_tag),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_y(out_y), .out_tag(out_tag), .out_flags(out_flags)
   );

   fp_addsub_pipe #(.EXP_W(5), .MAN_W(10), .TAG_W(TAG_W)) dut_h (
      .clk(clk), .rst(rst),
      .in_valid(h_in_valid), .in_ready(h_in_ready), .in_op(h_in_op),
      .in_x1(h_in_x1), .in_x2(h_in_x2), .in_tag(h_in_tag),
      .out_valid(h_out_valid), .out_ready(h_out_ready),
      .out_y(h_out_y), .out_tag(h_out_tag), .out_flags(h_out_flags)
   );

   task automatic chk(input string nm, input logic [63:0] obs, input logic [63:0] exp_v);
      total++;
      assert (obs === exp_v) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", nm, obs, exp_v);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic run_op(input string nm, input logic op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [TAG_W-1:0] tg,
                         input logic [W-1:0] ey, input logic [3:0] ef);
      in_valid = 1'b1; in_op = op; in_x1 = a; in_x2 = b; in_tag = tg;
      #1;
      chk({nm, "_in_ready"}, 64'(in_ready), 64'(1'b1));
      step();
      in_valid = 1'b0;
      step();
      chk({nm, "_early"}, 64'(out_valid), 64'(1'b0));
      step();
      chk({nm, "_valid"}, 64'(out_valid), 64'(1'b1));
      chk({nm, "_y"},     64'(out_y),     64'(ey));
      chk({nm, "_tag"},   64'(out_tag),   64'(tg));
      chk({nm, "_flags"}, 64'(out_flags), 64'(ef));
      step();
      chk({nm, "_drain"}, 64'(out_valid), 64'(1'b0));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [2:0]         pv;
      logic               en_m;
      logic [W+TAG_W-1:0] front;
      int                 n_tx, n_rx;

      rst = 1'b1; in_valid = 1'b0; in_op = 1'b0; in_x1 = '0; in_x2 = '0; in_tag = '0;
      out_ready = 1'b1;
      h_in_valid = 1'b0; h_in_op = 1'b0; h_in_x1 = '0; h_in_x2 = '0; h_in_tag = '0;
      h_out_ready = 1'b1;

      // reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst_valid", 64'(out_valid), 64'(1'b0));
      chk("rst_y",     64'(out_y),     64'(0));
      chk("rst_tag",   64'(out_tag),   64'(0));
      chk("rst_flags", 64'(out_flags), 64'(0));
      chk("rst_h_valid", 64'(h_out_valid), 64'(1'b0));
      #2 rst = 1'b0;
      #1;
      chk("rst_in_ready", 64'(in_ready), 64'(1'b1));
      step();

      // directed vectors
      run_op("add_1_2",    1'b0, 32'h3F800000, 32'h40000000, 4'd5,  32'h40400000, 4'b0000);
      run_op("sub_eq",     1'b1, 32'h3F800000, 32'h3F800000, 4'd1,  32'h00000000, 4'b0000);
      run_op("sub_ulp",    1'b1, 32'h3F800000, 32'h33800000, 4'd2,  32'h3F7FFFFF, 4'b0000);
      run_op("tie_even",   1'b0, 32'h3F800000, 32'h33800000, 4'd3,  32'h3F800000, 4'b0001);
      run_op("tie_odd",    1'b0, 32'h3F800001, 32'h33800000, 4'd4,  32'h3F800002, 4'b0001);
      run_op("rnd_carry",  1'b0, 32'h3FFFFFFF, 32'h33800000, 4'd6,  32'h40000000, 4'b0001);
      run_op("overflow",   1'b0, 32'h7F7FFFFF, 32'h7F7FFFFF, 4'd7,  32'h7F800000, 4'b0101);
      run_op("inf_m_inf",  1'b0, 32'h7F800000, 32'hFF800000, 4'd8,  32'h7FC00000, 4'b1000);
      run_op("nan_in",     1'b0, 32'h7FC12345, 32'h3F800000, 4'd9,  32'h7FC00000, 4'b0000);
      run_op("inf_fin",    1'b0, 32'h7F800000, 32'h3F800000, 4'd10, 32'h7F800000, 4'b0000);
      run_op("neg_zeros",  1'b0, 32'h80000000, 32'h80000000, 4'd11, 32'h80000000, 4'b0000);
      run_op("underflow",  1'b1, 32'h80800001, 32'h80800000, 4'd12, 32'h80000000, 4'b0011);
      run_op("sticky_far", 1'b0, 32'h3F800000, 32'h00800000, 4'd13, 32'h3F800000, 4'b0001);
      run_op("subnorm_in", 1'b0, 32'h3F800000, 32'h00000001, 4'd14, 32'h3F800000, 4'b0000);

      // half precision
      h_in_valid = 1'b1; h_in_op = 1'b0; h_in_x1 = 16'h3C00; h_in_x2 = 16'h4000; h_in_tag = 4'd3;
      step();
      h_in_valid = 1'b0;
      step();
      chk("half_early", 64'(h_out_valid), 64'(1'b0));
      step();
      chk("half_valid", 64'(h_out_valid), 64'(1'b1));
      chk("half_y",     64'(h_out_y),     64'(16'h4200));
      chk("half_tag",   64'(h_out_tag),   64'(4'd3));
      chk("half_flags", 64'(h_out_flags), 64'(4'b0000));
      step();

      // backpressure stream with a valid-bit model of the three stages
      pv = '0; n_tx = 0; n_rx = 0; exp_q.delete();
      for (int c = 0; c < 40 && n_rx < 6; c++) begin
         out_ready = !(c >= 4 && c < 9);
         if (n_tx < 6) begin
            in_valid = 1'b1; in_op = 1'b0; in_x1 = 32'h3F800000;
            in_x2 = bp_x2[n_tx]; in_tag = TAG_W'(n_tx);
         end else begin
            in_valid = 1'b0;
         end
         #1;
         en_m = !pv[2] || out_ready;
         chk("bp_in_ready",  64'(in_ready),  64'(en_m));
         chk("bp_out_valid", 64'(out_valid), 64'(pv[2]));
         if (pv[2]) begin
            front = exp_q[0];
            chk("bp_y",     64'(out_y),     64'(front[W-1:0]));
            chk("bp_tag",   64'(out_tag),   64'(front[W+TAG_W-1:W]));
            chk("bp_flags", 64'(out_flags), 64'(4'b0000));
            if (out_ready) begin
               void'(exp_q.pop_front());
               n_rx++;
            end
         end
         if (en_m) begin
            if (in_valid) begin
               exp_q.push_back({in_tag, bp_y[n_tx]});
               n_tx++;
            end
            pv = {pv[1:0], in_valid};
         end
         step();
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      chk("bp_sent",     64'(n_tx), 64'(6));
      chk("bp_received", 64'(n_rx), 64'(6));
      chk("bp_leftover", 64'(exp_q.size()), 64'(0));
      step();
      chk("bp_idle", 64'(out_valid), 64'(1'b0));

      // asynchronous reset with two ops in flight
      out_ready = 1'b0;
      in_valid = 1'b1; in_op = 1'b0; in_x1 = 32'h3F800000; in_x2 = 32'h3F800000; in_tag = 4'd9;
      step();
      in_x2 = 32'h40000000; in_tag = 4'd10;
      step();
      in_valid = 1'b0;
      step();
      chk("mid_valid", 64'(out_valid), 64'(1'b1));
      #2 rst = 1'b1;
      #1;
      chk("async_valid", 64'(out_valid), 64'(1'b0));
      chk("async_y",     64'(out_y),     64'(0));
      chk("async_tag",   64'(out_tag),   64'(0));
      chk("async_flags", 64'(out_flags), 64'(0));
      step();
      #2 rst = 1'b0;
      #1;
      chk("post_rst_ready", 64'(in_ready), 64'(1'b1));
      out_ready = 1'b1;
      step();
      for (int c = 0; c < 6; c++) begin
         chk("no_ghost", 64'(out_valid), 64'(1'b0));
         step();
      end
      run_op("post_rst", 1'b0, 32'h40000000, 32'h40000000, 4'd15, 32'h40800000, 4'b0000);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/fp_addsub_pipe.md
Name: fp_addsub_pipe

Overview:
- Parametrised IEEE-754-style floating-point adder/subtractor with a run-time op select.
- Three-stage pipeline with valid/ready flow control, an in-order tag sideband and exception flags.
- Successor to the fixed-format, free-running single-precision subtractor in the FPU pipeline.
- Sits between the FPU issue stage and the writeback arbiter; must tolerate writeback backpressure.

Parameters:
- EXP_W, 8, exponent field width (≥4).
- MAN_W, 23, stored mantissa field width (≥4); word width W = 1+EXP_W+MAN_W.
- TAG_W, 4, width of the opaque tag carried with each operation.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  operation offered.
- in_ready  out  1  block accepts when in_valid&&in_ready.
- in_op  in  1  0 = x1+x2, 1 = x1-x2 (x2 sign inverted).
- in_x1  in  W  operand 1.
- in_x2  in  W  operand 2.
- in_tag  in  TAG_W  sideband, returned unchanged.
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes result when out_valid&&out_ready.
- out_y  out  W  result.
- out_tag  out  TAG_W  tag of this result.
- out_flags  out  4  {nv, ovf, unf, nx}.

Behaviour:
- Pipeline: stage 1 = align and select; stage 2 = add/sub and leading-zero count; stage 3 = normalise, round, pack. Latency 3 cycles from accept to out_valid with no stall.
- Each stage register has a valid bit; the global advance is en = !v3 || out_ready.
- in_ready = en, combinational. All stage registers load only when en=1.
- A bubble entering a stage clears that stage's valid bit.
- Stall: while out_valid=1 and out_ready=0, every stage holds, and out_y/out_tag/out_flags stay stable.
- Throughput: 1 op/cycle. Results leave in acceptance order. No reordering, no dropping.
- Reset (asynchronous, any time, including mid-operation): all valid bits → 0, so out_valid=0, out_y=0, out_tag=0, out_flags=0. In-flight ops are discarded. in_ready=1 once rst deasserts.
- Subnormal inputs (exp=0) are treated as signed zero. Result magnitudes below the minimum normal flush to zero with the result sign: unf=1, nx=1.
- Exact zero from a sum of opposite-signed equal magnitudes → +0. (+0)+(+0) → +0; (−0)+(−0) → −0.
- Alignment: the smaller operand is shifted right by the exponent difference. Any difference ≥ MAN_W+3 collapses the operand into the sticky bit. Guard, round and sticky bits are kept.
- Magnitude select: larger exponent wins; on equal exponents, the larger mantissa wins; the result sign is the sign of the winner.
- Rounding is round-to-nearest-even. nx=1 if any guard/round/sticky bit is nonzero.
- A rounding carry out of the mantissa increments the exponent.
- Overflow (final exponent ≥ all-ones): y = ±infinity, ovf=1, nx=1.
- Special cases:
  - Any NaN input → canonical NaN (sign 0, exp all-ones, mantissa MSB=1, rest 0); nv=0 unless the inf−inf rule applies.
  - inf plus opposite-signed inf (after op inversion) → canonical NaN, nv=1.
  - inf plus finite → that inf, flags 0.
- Flags are valid only with out_valid. Unused flags are 0.

Test Plan:
- Single-precision defaults, out_ready=1: issue 0x3F800000 + 0x40000000, tag 5 → after 3 cycles out_y=0x40400000, tag=5, flags=0000.
- in_op=1 with 0x3F800000 − 0x3F800000 → 0x00000000, flags=0000. Then 0x3F800000 − 0x33800000 → 0x3F7FFFFF, nx=0.
- Rounding tie, 0x3F800000 + 0x33800000 → 0x3F800000, nx=1. Also 0x3F800001 + 0x33800000 → 0x3F800002, nx=1.
- Specials: 0x7F7FFFFF + 0x7F7FFFFF → 0x7F800000 with ovf=1, nx=1. 0x7F800000 + 0xFF800000 → 0x7FC00000 with nv=1. 0x7FC12345 + 0x3F800000 → 0x7FC00000 with nv=0.
- Backpressure: stream 6 ops with tags 0–5 and hold out_ready=0 from cycle 4 for 5 cycles.
  - in_ready drops once 3 ops are held.
  - out_y is stable throughout the stall.
  - After release, all 6 results arrive in tag order 0–5, none lost or duplicated.
- Reset: assert rst asynchronously mid-stream with 2 ops in flight → out_valid=0 immediately. After deassertion, neither op ever appears and the next op completes 3 cycles after acceptance. Repeat with EXP_W=5, MAN_W=10: 0x3C00 + 0x4000 → 0x4200.
